// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D line-transfer memory arbiter.
package mem_arb_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int AW             = 16;
  localparam int IDX_W          = 2;
  localparam int WORD_LSB       = 1;
  localparam int LINE_LSB       = WORD_LSB + IDX_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef enum logic       {OWN_I, OWN_D}       owner_t;

  // Byte address of one 16-bit word inside a latched line.
  function automatic logic [AW-1:0] wordAddr(input logic [AW-1:LINE_LSB] line,
                                             input logic [IDX_W-1:0]     idx);
    logic [AW-1:0] a;
    a                    = '0;
    a[AW-1:LINE_LSB]     = line;
    a[WORD_LSB +: IDX_W] = idx;
    return a;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the line-transfer arbiter.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic             i_req, d_req;
  logic             i_wr, d_wr;
  logic [AW-1:0]    i_addr, d_addr;
  logic [15:0]      i_wdata, d_wdata;
  logic             i_grant, d_grant;
  logic [IDX_W-1:0] word_idx;
  logic             i_rvalid, d_rvalid;
  logic [IDX_W-1:0] rd_idx;
  logic [15:0]      rd_data;
  logic             i_done, d_done;
  logic             mem_en, mem_wr;
  logic [AW-1:0]    mem_addr;
  logic [15:0]      mem_wdata;
  logic             mem_stall, mem_rvalid;
  logic [15:0]      mem_rdata;

  modport slave (
    input  i_req, d_req, i_wr, d_wr, i_addr, d_addr, i_wdata, d_wdata,
           mem_stall, mem_rvalid, mem_rdata,
    output i_grant, d_grant, word_idx, i_rvalid, d_rvalid, rd_idx, rd_data,
           i_done, d_done, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, d_req, i_wr, d_wr, i_addr, d_addr, i_wdata, d_wdata,
           mem_stall, mem_rvalid, mem_rdata,
    input  i_grant, d_grant, word_idx, i_rvalid, d_rvalid, rd_idx, rd_data,
           i_done, d_done, mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the side that did not win last time wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   iReq_i,
  input  logic   dReq_i,
  input  owner_t last_i,
  output owner_t winner_o,
  output logic   valid_o
);

  always_comb begin
    winner_o = OWN_I;
    valid_o  = iReq_i | dReq_i;
    if (iReq_i && dReq_i) begin
      winner_o = (last_i == OWN_I) ? OWN_D : OWN_I;
    end else if (dReq_i) begin
      winner_o = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Line-transfer arbiter: shares one memory port between the I- and D-cache engines,
// issuing four word accesses per line and steering read returns to the owner.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  state_t               state_q, state_d;
  owner_t               owner_q, owner_d;
  owner_t               last_q, last_d;
  logic                 wr_q, wr_d;
  logic [AW-1:LINE_LSB] line_q, line_d;
  logic [IDX_W-1:0]     ic_q, ic_d;
  logic [IDX_W-1:0]     rc_q, rc_d;
  logic                 wrDone_q, wrDone_d;

  logic   iReqEff, dReqEff, pickValid;
  owner_t pickOwner;
  logic   retValid, lastRet, active, doneNow;
  logic   unusedAddrBits;

  // A finishing writer still holds req during its done cycle; keep it from re-winning.
  assign iReqEff = bus.i_req && !(wrDone_q && owner_q == OWN_I);
  assign dReqEff = bus.d_req && !(wrDone_q && owner_q == OWN_D);
  assign unusedAddrBits = ^{bus.i_addr[LINE_LSB-1:0], bus.d_addr[LINE_LSB-1:0]};

  rr_pick2 uPick (
    .iReq_i   (iReqEff),
    .dReq_i   (dReqEff),
    .last_i   (last_q),
    .winner_o (pickOwner),
    .valid_o  (pickValid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      last_q   <= OWN_I;
      wr_q     <= 1'b0;
      line_q   <= '0;
      ic_q     <= '0;
      rc_q     <= '0;
      wrDone_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      line_q   <= line_d;
      ic_q     <= ic_d;
      rc_q     <= rc_d;
      wrDone_q <= wrDone_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wr_d     = wr_q;
    line_d   = line_q;
    ic_d     = ic_q;
    rc_d     = rc_q;
    wrDone_d = 1'b0;
    retValid = 1'b0;
    lastRet  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d = ISSUE;
          owner_d = pickOwner;
          last_d  = pickOwner;
          wr_d    = (pickOwner == OWN_D) ? bus.d_wr : bus.i_wr;
          line_d  = (pickOwner == OWN_D) ? bus.d_addr[AW-1:LINE_LSB]
                                         : bus.i_addr[AW-1:LINE_LSB];
          ic_d    = '0;
          rc_d    = '0;
        end
      end
      ISSUE, DRAIN: begin
        if (state_q == ISSUE && !bus.mem_stall) begin
          if (ic_q == LAST_IDX) begin
            if (wr_q) begin
              state_d  = IDLE;
              wrDone_d = 1'b1;
            end else begin
              state_d  = DRAIN;
            end
          end else begin
            ic_d = ic_q + 2'd1;
          end
        end
        // The final return ends the transfer even if it lands alongside the last issue.
        if (!wr_q && bus.mem_rvalid) begin
          retValid = 1'b1;
          if (rc_q == LAST_IDX) begin
            lastRet = 1'b1;
            state_d = IDLE;
          end else begin
            rc_d = rc_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign active  = (state_q != IDLE) || wrDone_q;
  assign doneNow = wrDone_q || lastRet;

  assign bus.i_grant   = active && (owner_q == OWN_I);
  assign bus.d_grant   = active && (owner_q == OWN_D);
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_wr    = (state_q == ISSUE) && wr_q;
  assign bus.word_idx  = (state_q == ISSUE) ? ic_q : '0;
  assign bus.mem_addr  = (state_q == ISSUE) ? wordAddr(line_q, ic_q) : '0;
  assign bus.mem_wdata = (state_q != ISSUE) ? 16'h0000 :
                         (owner_q == OWN_D) ? bus.d_wdata : bus.i_wdata;
  assign bus.i_rvalid  = retValid && (owner_q == OWN_I);
  assign bus.d_rvalid  = retValid && (owner_q == OWN_D);
  assign bus.rd_idx    = retValid ? rc_q : '0;
  assign bus.rd_data   = retValid ? bus.mem_rdata : 16'h0000;
  assign bus.i_done    = doneNow && (owner_q == OWN_I);
  assign bus.d_done    = doneNow && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, cycle-by-cycle vector bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        iReq, iWr;
    logic [15:0] iAddr;
    logic        dReq, dWr;
    logic [15:0] dAddr;
    logic        stall, rvalid;
    logic [15:0] rdata;
  } in_t;

  typedef struct packed {
    logic        iGrant, dGrant, memEn, memWr;
    logic [1:0]  wordIdx;
    logic [15:0] memAddr, memWdata;
    logic        iRvalid, dRvalid;
    logic [1:0]  rdIdx;
    logic [15:0] rdData;
    logic        iDone, dDone;
  } out_t;

  typedef struct packed {
    in_t        stim;
    out_t       exp;
    logic [7:0] scen;
    logic [7:0] cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  // Requesters present a recognisable word per index.
  assign bus.i_wdata = 16'hA000 | {14'd0, bus.word_idx};
  assign bus.d_wdata = 16'hD000 | {14'd0, bus.word_idx};

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   vecCount  = 0;
  int   missCount = 0;
  int   curScen   = 0;
  int   curCyc    = 0;
  vec_t vecs[$];

  function automatic in_t mkIn(logic iReq, logic iWr, logic [15:0] iAddr,
                               logic dReq, logic dWr, logic [15:0] dAddr,
                               logic stall, logic rv, logic [15:0] rdata);
    in_t s;
    s.iReq = iReq;  s.iWr = iWr;  s.iAddr = iAddr;
    s.dReq = dReq;  s.dWr = dWr;  s.dAddr = dAddr;
    s.stall = stall; s.rvalid = rv; s.rdata = rdata;
    return s;
  endfunction

  function automatic in_t dIn(logic req, logic wr, logic [15:0] addr,
                              logic stall, logic rv, logic [15:0] rdata);
    return mkIn(1'b0, 1'b0, 16'h0, req, wr, addr, stall, rv, rdata);
  endfunction

  function automatic in_t iIn(logic req, logic wr, logic [15:0] addr,
                              logic stall, logic rv, logic [15:0] rdata);
    return mkIn(req, wr, addr, 1'b0, 1'b0, 16'h0, stall, rv, rdata);
  endfunction

  function automatic out_t grantOut(bit isD);
    out_t o = '0;
    if (isD) o.dGrant = 1'b1;
    else     o.iGrant = 1'b1;
    return o;
  endfunction

  function automatic out_t issueOut(bit isD, bit wr, logic [15:0] base, int k);
    out_t o = grantOut(isD);
    o.memEn    = 1'b1;
    o.memWr    = wr;
    o.wordIdx  = 2'(k);
    o.memAddr  = base + 16'(2 * k);
    o.memWdata = (isD ? 16'hD000 : 16'hA000) + 16'(k);
    return o;
  endfunction

  function automatic out_t withDone(out_t o, bit isD);
    if (isD) o.dDone = 1'b1;
    else     o.iDone = 1'b1;
    return o;
  endfunction

  function automatic out_t withRet(out_t o, bit isD, int k, logic [15:0] data, bit done);
    if (isD) o.dRvalid = 1'b1;
    else     o.iRvalid = 1'b1;
    o.rdIdx  = 2'(k);
    o.rdData = data;
    if (done) o = withDone(o, isD);
    return o;
  endfunction

  task automatic addVec(input in_t s, input out_t e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    v.scen = 8'(curScen);
    v.cyc  = 8'(curCyc);
    vecs.push_back(v);
    curCyc++;
  endtask

  task automatic applyStimulus(input in_t s, input logic rstN);
    rst_n          = rstN;
    bus.i_req      = s.iReq;
    bus.i_wr       = s.iWr;
    bus.i_addr     = s.iAddr;
    bus.d_req      = s.dReq;
    bus.d_wr       = s.dWr;
    bus.d_addr     = s.dAddr;
    bus.mem_stall  = s.stall;
    bus.mem_rvalid = s.rvalid;
    bus.mem_rdata  = s.rdata;
  endtask

  task automatic checkOutput(input out_t e, input string tag);
    out_t a;
    a.iGrant   = bus.i_grant;
    a.dGrant   = bus.d_grant;
    a.memEn    = bus.mem_en;
    a.memWr    = bus.mem_wr;
    a.wordIdx  = bus.word_idx;
    a.memAddr  = bus.mem_addr;
    a.memWdata = bus.mem_wdata;
    a.iRvalid  = bus.i_rvalid;
    a.dRvalid  = bus.d_rvalid;
    a.rdIdx    = bus.rd_idx;
    a.rdData   = bus.rd_data;
    a.iDone    = bus.i_done;
    a.dDone    = bus.d_done;
    vecCount++;
    if (a !== e) begin
      missCount++;
      $display("[TB] FAIL %s: got=%h required=%h", tag, a, e);
    end
  endtask

  task automatic step(input in_t s, input logic rstN, input out_t e, input string tag);
    @(negedge clk);
    applyStimulus(s, rstN);
    #2;
    checkOutput(e, tag);
  endtask

  task automatic buildTable();
    in_t both;
    both = mkIn(1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0);

    // Scenario 0: simultaneous writebacks after reset -> D, I, D, then a tie goes to I.
    curScen = 0; curCyc = 0;
    addVec(both, '0);
    for (int k = 0; k < 4; k++) addVec(both, issueOut(1, 1, 16'h0200, k));
    addVec(both, withDone(grantOut(1), 1));
    for (int k = 0; k < 4; k++) addVec(both, issueOut(0, 1, 16'h0100, k));
    addVec(both, withDone(grantOut(0), 0));
    for (int k = 0; k < 4; k++) addVec(dIn(1, 1, 16'h0200, 0, 0, 16'h0), issueOut(1, 1, 16'h0200, k));
    addVec(dIn(1, 1, 16'h0200, 0, 0, 16'h0), withDone(grantOut(1), 1));
    addVec(both, '0);
    for (int k = 0; k < 4; k++) addVec(iIn(1, 1, 16'h0100, 0, 0, 16'h0), issueOut(0, 1, 16'h0100, k));
    addVec(iIn(1, 1, 16'h0100, 0, 0, 16'h0), withDone(grantOut(0), 0));
    addVec('0, '0);

    // Scenario 1: lone D fill at 0x1238, memory latency 2.
    curScen = 1; curCyc = 0;
    for (int c = 0; c < 8; c++) begin
      bit   rv;
      out_t e;
      rv = (c >= 3 && c <= 6);
      e  = '0;
      if (c >= 1 && c <= 4) e = issueOut(1, 0, 16'h1238, c - 1);
      else if (c == 5 || c == 6) e = grantOut(1);
      if (rv) e = withRet(e, 1, c - 3, 16'h5500 + 16'(c - 3), c == 6);
      addVec(dIn(c <= 6, 0, 16'h1238, 0, rv, rv ? 16'h5500 + 16'(c - 3) : 16'h0), e);
    end

    // Scenario 2: lone I writeback at 0x0040.
    curScen = 2; curCyc = 0;
    addVec(iIn(1, 1, 16'h0040, 0, 0, 16'h0), '0);
    for (int k = 0; k < 4; k++) addVec(iIn(1, 1, 16'h0040, 0, 0, 16'h0), issueOut(0, 1, 16'h0040, k));
    addVec(iIn(1, 1, 16'h0040, 0, 0, 16'h0), withDone(grantOut(0), 0));
    addVec('0, '0);

    // Scenario 3: D fill at 0x2005 (low bits ignored) with 3 stall cycles on word 2.
    curScen = 3; curCyc = 0;
    addVec(dIn(1, 0, 16'h2005, 0, 0, 16'h0), '0);
    addVec(dIn(1, 0, 16'h2005, 0, 0, 16'h0), issueOut(1, 0, 16'h2000, 0));
    addVec(dIn(1, 0, 16'h2005, 0, 0, 16'h0), issueOut(1, 0, 16'h2000, 1));
    addVec(dIn(1, 0, 16'h2005, 1, 1, 16'h6600), withRet(issueOut(1, 0, 16'h2000, 2), 1, 0, 16'h6600, 0));
    addVec(dIn(1, 0, 16'h2005, 1, 1, 16'h6601), withRet(issueOut(1, 0, 16'h2000, 2), 1, 1, 16'h6601, 0));
    addVec(dIn(1, 0, 16'h2005, 1, 0, 16'h0), issueOut(1, 0, 16'h2000, 2));
    addVec(dIn(1, 0, 16'h2005, 0, 0, 16'h0), issueOut(1, 0, 16'h2000, 2));
    addVec(dIn(1, 0, 16'h2005, 0, 0, 16'h0), issueOut(1, 0, 16'h2000, 3));
    addVec(dIn(1, 0, 16'h2005, 0, 1, 16'h6602), withRet(grantOut(1), 1, 2, 16'h6602, 0));
    addVec(dIn(1, 0, 16'h2005, 0, 1, 16'h6603), withRet(grantOut(1), 1, 3, 16'h6603, 1));
    addVec('0, '0);

    // Scenario 4: D fill at 0x3000, latency 1, req dropped one cycle after grant.
    curScen = 4; curCyc = 0;
    addVec(dIn(1, 0, 16'h3000, 0, 0, 16'h0), '0);
    addVec(dIn(1, 0, 16'h3000, 0, 0, 16'h0), issueOut(1, 0, 16'h3000, 0));
    for (int k = 1; k < 4; k++)
      addVec(dIn(0, 0, 16'h3000, 0, 1, 16'h7700 + 16'(k - 1)),
             withRet(issueOut(1, 0, 16'h3000, k), 1, k - 1, 16'h7700 + 16'(k - 1), 0));
    addVec(dIn(0, 0, 16'h3000, 0, 1, 16'h7703), withRet(grantOut(1), 1, 3, 16'h7703, 1));
    addVec('0, '0);
  endtask

  initial begin
    applyStimulus('0, 1'b0);
    #2;
    checkOutput('0, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    buildTable();
    foreach (vecs[n]) begin
      step(vecs[n].stim, 1'b1, vecs[n].exp, $sformatf("s%0d c%0d", vecs[n].scen, vecs[n].cyc));
    end

    // Reset in DRAIN with two words outstanding, stale returns, then a fresh I fill.
    step(dIn(1, 0, 16'h4000, 0, 0, 16'h0), 1'b1, '0, "rst c0");
    for (int k = 0; k < 3; k++)
      step(dIn(1, 0, 16'h4000, 0, 0, 16'h0), 1'b1, issueOut(1, 0, 16'h4000, k), $sformatf("rst c%0d", k + 1));
    step(dIn(1, 0, 16'h4000, 0, 1, 16'h8800), 1'b1,
         withRet(issueOut(1, 0, 16'h4000, 3), 1, 0, 16'h8800, 0), "rst c4");
    step(dIn(1, 0, 16'h4000, 0, 1, 16'h8801), 1'b1, withRet(grantOut(1), 1, 1, 16'h8801, 0), "rst c5");
    step(dIn(1, 0, 16'h4000, 0, 1, 16'h8802), 1'b0, '0, "rst async");
    step(dIn(0, 0, 16'h4000, 0, 1, 16'h8803), 1'b1, '0, "rst stale1");
    step(iIn(1, 0, 16'h0500, 0, 1, 16'h8899), 1'b1, '0, "rst stale2");
    step(iIn(1, 0, 16'h0500, 0, 0, 16'h0), 1'b1, issueOut(0, 0, 16'h0500, 0), "rst i0");
    for (int k = 1; k < 4; k++)
      step(iIn(1, 0, 16'h0500, 0, 1, 16'h9900 + 16'(k - 1)), 1'b1,
           withRet(issueOut(0, 0, 16'h0500, k), 0, k - 1, 16'h9900 + 16'(k - 1), 0),
           $sformatf("rst i%0d", k));
    step(iIn(1, 0, 16'h0500, 0, 1, 16'h9903), 1'b1, withRet(grantOut(0), 0, 3, 16'h9903, 1), "rst idone");
    step('0, 1'b1, '0, "rst idle");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
